decoder_scan_seq: RTL
=====================

Name: decoder_scan_seq

Overview:
- Upstream sequencer for the 3-to-8 decoder stage.
- Steps a 3-bit channel code `din` across a channel mask, holding `en` high for a programmable dwell per channel.
- Inserts a one-cycle `en`-low guard between channels, so the decoder's one-hot outputs are break-before-make.
- Supports single-sweep and continuous modes, with start/stop control and a done pulse.

Parameters:
- DWELL_W, 8, width of the dwell count input; each channel is held for dwell+1 cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  begin scan; sampled only in IDLE
- stop  input  1  abort scan; takes effect on the next edge
- cont  input  1  1 = continuous wrap, 0 = single sweep; latched at start
- mask  input  8  channel enable bits, bit i = channel i; latched at start
- dwell  input  DWELL_W  hold count per channel; latched at start
- din  output  3  channel code to the decoder
- en  output  1  decoder enable
- busy  output  1  high while not in IDLE
- done  output  1  one-cycle pulse at the end of a single sweep

Behaviour:
- Reset, synchronous and dominant over all other inputs: din=0, en=0, busy=0, done=0, state=IDLE, dwell counter=0.
- All outputs are registered.
- States: IDLE, SEEK, DWELL.
- IDLE:
  - start=1 and stop=0 → latch mask/dwell/cont.
  - If the latched mask is nonzero → SEEK, busy=1, with the channel pointer set to "before channel 0".
  - If the mask is 0 → stay in IDLE, pulse done=1 for one cycle, busy stays 0.
  - start with stop in the same cycle → stop wins; remain in IDLE with no done.
- SEEK, exactly one cycle, en=0, din holds its previous value:
  - Select the lowest set mask bit with index greater than the pointer.
  - Go to DWELL with din=index, en=1, counter=dwell.
- DWELL, en=1:
  - Each edge: if counter≠0, decrement.
  - If counter=0 and the current channel is not the highest set mask bit → SEEK with en=0.
  - If counter=0 and it is the highest set bit:
    - cont=1 → SEEK with the pointer wrapped to "before channel 0", so the lowest set bit is chosen next.
    - cont=0 → IDLE with en=0, din=0, busy=0, done=1 for one cycle.
  - en is high for exactly dwell+1 consecutive cycles per channel. dwell=0 gives 1 cycle.
- Latency: start sampled at edge k → busy=1 after edge k; first en=1 after edge k+1.
- Single-sweep length: done asserts after edge k + N·(dwell+2), where N = popcount(mask).
- stop=1 in SEEK or DWELL → next edge goes to IDLE: en=0, din=0, busy=0, no done pulse.
- start while busy is ignored. mask/dwell/cont changes while busy are ignored until the next start.
- Single-channel mask with cont=1: en high dwell+1 cycles, low 1 cycle, repeating on the same din.
- done and busy are never high in the same cycle.
- din never changes while en=1.

Optional Feature:
- Macro SCAN_CNT_EN.
- When defined: add output `sweep_cnt`, 8 bits.
  - Cleared to 0 on rst and on an accepted start.
  - Incremented when the highest enabled channel completes its dwell, in both modes.
  - Saturates at 255. Holds its value in IDLE.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-DWELL (mask=8'hFF, dwell=5, rst high one cycle) → next cycle din=0, en=0, busy=0, done=0; start is accepted again afterwards.
- mask=8'b1010_0101, dwell=2, cont=0, start at edge k → en=1 for 3 cycles each with din=0, 2, 5, 7, one en=0 cycle between channels; done=1 only in the cycle after edge k+16, then busy=0.
- mask=8'h80, dwell=0, cont=1 → din=7 constant; en alternates 1,0,1,0 from edge k+1; stop at any cycle → en=0, busy=0 on the next cycle, no done.
- mask=8'h00, start → busy stays 0, en stays 0, done=1 for exactly one cycle after the start edge; start+stop together in IDLE → nothing happens.
- Mid-scan perturbation (mask=8'h0F, dwell=3, cont=0): toggle start, mask and dwell during the scan → sequence unchanged (din 0,1,2,3, each for 4 cycles); done asserts after edge k+20.
- With SCAN_CNT_EN (mask=8'h03, dwell=1, cont=1): run 3 full sweeps → sweep_cnt=3; new start → sweep_cnt=0; long run → sweep_cnt saturates at 255.

Source files
------------

// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq
//   Upstream sequencer for the 3-to-8 decoder stage. Steps a 3-bit channel
//   code across a latched channel mask. Each enabled channel gets en high
//   for dwell+1 cycles, followed by a single en-low guard cycle, so the
//   decoder outputs are break-before-make. Supports single-sweep and
//   continuous modes, start/stop control and a done pulse.
//
// Optional feature: define SCAN_CNT_EN to add the sweep_cnt output, a
//   saturating count of completed sweeps.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high, dominant
//   start      in   begin scan, sampled only in IDLE
//   stop       in   abort scan, wins over start
//   cont       in   1 = continuous wrap, 0 = single sweep (latched at start)
//   mask[7:0]  in   channel enable bits (latched at start)
//   dwell      in   hold count per channel (latched at start)
//   din[2:0]   out  channel code to the decoder
//   en         out  decoder enable
//   busy       out  high while not in IDLE
//   done       out  one-cycle pulse at the end of a single sweep
//   sweep_cnt  out  completed sweep count, saturating (SCAN_CNT_EN only)
module decoder_scan_seq #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         din,
    output logic               en,
    output logic               busy,
`ifdef SCAN_CNT_EN
    output logic               done,
    output logic [7:0]         sweep_cnt
`else
    output logic               done
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StDwell
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    // Set when the pointer sits "before channel 0": the next seek picks the
    // lowest set bit regardless of the current din.
    logic               wrap_q, wrap_d;
    logic [2:0]         din_q, din_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2:0]         next_ch;
    logic               is_last;

`ifdef SCAN_CNT_EN
    logic [7:0]         sweep_q, sweep_d;
    logic               sweep_clr;
    logic               sweep_inc;
`endif

    // Lowest set mask bit above the pointer. Scanning downward lets the
    // lowest qualifying index win the final assignment.
    always_comb begin
        next_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (wrap_q || (4'(i) > {1'b0, din_q}))) begin
                next_ch = 3'(i);
            end
        end
    end

    // Current channel is the highest set mask bit when nothing is set above it.
    always_comb begin
        is_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (mask_q[i] && (4'(i) > {1'b0, din_q})) begin
                is_last = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        wrap_d  = wrap_q;
        din_d   = din_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SCAN_CNT_EN
        sweep_clr = 1'b0;
        sweep_inc = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    mask_d  = mask;
                    dwell_d = dwell;
                    cont_d  = cont;
`ifdef SCAN_CNT_EN
                    sweep_clr = 1'b1;
`endif
                    if (mask != 8'd0) begin
                        state_d = StSeek;
                        busy_d  = 1'b1;
                        wrap_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            StSeek: begin
                if (stop) begin
                    state_d = StIdle;
                    en_d    = 1'b0;
                    din_d   = 3'd0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = StDwell;
                    din_d   = next_ch;
                    en_d    = 1'b1;
                    cnt_d   = dwell_q;
                    wrap_d  = 1'b0;
                end
            end

            StDwell: begin
                if (stop) begin
                    state_d = StIdle;
                    en_d    = 1'b0;
                    din_d   = 3'd0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!is_last) begin
                    state_d = StSeek;
                    en_d    = 1'b0;
                end else begin
`ifdef SCAN_CNT_EN
                    sweep_inc = 1'b1;
`endif
                    if (cont_q) begin
                        state_d = StSeek;
                        en_d    = 1'b0;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = StIdle;
                        en_d    = 1'b0;
                        din_d   = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                en_d    = 1'b0;
                din_d   = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mask_q  <= 8'd0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b1;
            din_q   <= 3'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            din_q   <= din_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SCAN_CNT_EN
    always_comb begin
        sweep_d = sweep_q;
        if (sweep_clr) begin
            sweep_d = 8'd0;
        end else if (sweep_inc && (sweep_q != 8'hFF)) begin
            sweep_d = sweep_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_q <= 8'd0;
        end else begin
            sweep_q <= sweep_d;
        end
    end

    assign sweep_cnt = sweep_q;
`endif

    assign din  = din_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
